// File: rtl/ioctl_dipsw_capture.sv
// ioctl_dipsw_capture: captures DIP-switch bytes from the HPS ioctl download
// bus into a shadow buffer and commits them atomically when the download ends.
// Optional feature macro: IOCTL_DIPSW_RESET_REQ_EN adds a core reset request
// pulse of RST_LEN cycles whenever a commit changes dipsw.

// Per-byte storage: shadow copy, written flag and committed value.
module ioctl_dipsw_byte (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       load_start,
   input  logic       wr_en,
   input  logic       commit,
   input  logic [7:0] din,
   output logic [7:0] shadow,
   output logic [7:0] dip,
   output logic       mask
);

   // Shadow reloads from the committed byte at download start so that
   // unwritten bytes commit back unchanged.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
         dip    <= '0;
         mask   <= 1'b0;
      end else begin
         if (load_start) begin
            shadow <= dip;
            mask   <= 1'b0;
         end else if (wr_en) begin
            shadow <= din;
            mask   <= 1'b1;
         end
         if (commit) dip <= shadow;
      end
   end

endmodule

module ioctl_dipsw_capture #(
   parameter int NUM_BYTES = 8,
   parameter int DIP_INDEX = 254,
   parameter int ADDR_W    = 25,
   parameter int RST_LEN   = 16
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [ADDR_W-1:0]      ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic [NUM_BYTES*8-1:0] dipsw,
   output logic                   dip_valid,
   output logic                   dip_changed,
   output logic                   dip_overflow,
   output logic                   busy,
   output logic                   dip_reset
);

   if (NUM_BYTES < 1 || NUM_BYTES > 32) begin : g_bad_num_bytes
      $error("ioctl_dipsw_capture: NUM_BYTES must be 1..32");
   end
   if (RST_LEN < 1 || RST_LEN > 255) begin : g_bad_rst_len
      $error("ioctl_dipsw_capture: RST_LEN must be 1..255");
   end

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   localparam logic [ADDR_W-1:0] NB_A  = ADDR_W'(NUM_BYTES);
   localparam logic [7:0]        IDX_V = 8'(DIP_INDEX);

   state_t state;
   logic   dl_q;      // previous ioctl_download, for edge detection
   logic   pend;      // DIP download start seen while in COMMIT

   logic [NUM_BYTES-1:0][7:0] shadow_all;
   logic [NUM_BYTES-1:0][7:0] dip_all;
   logic [NUM_BYTES-1:0]      mask_all;
   logic [NUM_BYTES-1:0]      wr_en;

   logic rise, idx_hit, start, wr_load, in_range, commit, diff;

   assign rise     = ioctl_download & ~dl_q;
   assign idx_hit  = (ioctl_index == IDX_V);
   assign start    = (state == IDLE) && ((rise && idx_hit) || pend);
   assign wr_load  = (state == LOAD) && ioctl_wr;
   assign in_range = (ioctl_addr < NB_A);
   assign commit   = (state == COMMIT);
   assign diff     = (shadow_all != dip_all);

   // One storage cell per DIP byte; full-width address decode so that any
   // upper address bit keeps the write out of the buffer.
   for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
      assign wr_en[k] = wr_load && (ioctl_addr == ADDR_W'(k));
      ioctl_dipsw_byte u_byte (
         .clk_sys    (clk_sys),
         .reset_n    (reset_n),
         .load_start (start),
         .wr_en      (wr_en[k]),
         .commit     (commit),
         .din        (ioctl_dout),
         .shadow     (shadow_all[k]),
         .dip        (dip_all[k]),
         .mask       (mask_all[k])
      );
   end

   assign dipsw = dip_all;

   // Control FSM with registered status outputs. dl_q resets high so a
   // download already in flight at reset release is not seen as a new start.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         dl_q         <= 1'b1;
         pend         <= 1'b0;
         dip_valid    <= 1'b0;
         dip_changed  <= 1'b0;
         dip_overflow <= 1'b0;
      end else begin
         dl_q        <= ioctl_download;
         dip_changed <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= LOAD;
                  busy         <= 1'b1;
                  pend         <= 1'b0;
                  dip_overflow <= 1'b0;
               end
            end
            LOAD: begin
               // A write in the cycle download drops is still taken.
               if (wr_load && !in_range) dip_overflow <= 1'b1;
               if (!ioctl_download) state <= COMMIT;
            end
            COMMIT: begin
               state       <= IDLE;
               busy        <= 1'b0;
               dip_changed <= diff;
               if (|mask_all) dip_valid <= 1'b1;
               if (rise && idx_hit) pend <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef IOCTL_DIPSW_RESET_REQ_EN
   logic [7:0] rst_cnt;

   // Hold counter: loads on every changing commit, so a new change during
   // the hold restarts the full length.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rst_cnt <= '0;
      end else if (commit && diff) begin
         rst_cnt <= 8'(RST_LEN);
      end else if (rst_cnt != 8'd0) begin
         rst_cnt <= rst_cnt - 8'd1;
      end
   end

   assign dip_reset = (rst_cnt != 8'd0);
`else
   assign dip_reset = 1'b0;
`endif

endmodule
